// File: rtl/state_pkg.sv
// Shared screen encoding and default geometry/timing for the game sequencer.
package state_pkg;

  // Screen currently shown by the VGA stage multiplexer; 2'b11 is unused.
  typedef enum logic [1:0] {
    START   = 2'b00,
    LEVEL_1 = 2'b01,
    FINISH  = 2'b10
  } g_state;

  // Start-button box on the START screen (inclusive edges).
  localparam logic [11:0] START_BTN_X0 = 12'd350;
  localparam logic [11:0] START_BTN_X1 = 12'd450;
  localparam logic [11:0] START_BTN_Y0 = 12'd280;
  localparam logic [11:0] START_BTN_Y1 = 12'd320;

  // Both players must reach this x position to leave LEVEL_1.
  localparam logic [11:0] LEVEL1_EXIT_X = 12'd740;

  // Frames the FINISH screen is held before returning to START (3 s at 60 Hz).
  localparam int unsigned FINISH_HOLD_FRAMES = 180;

  // Unsigned inclusive range test used for the start-button hit box.
  function automatic logic in_range(input logic [11:0] v,
                                    input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector; the pulse is combinational from
// the live input and the previous-cycle sample.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  // Remember last cycle's level; reset to 0 so a high input at release
  // produces an immediate edge.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) r_sig_q <= 1'b0;
    else        r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/game_state_ctl.sv
// Top-level game sequencer: START -> LEVEL_1 -> FINISH -> START.
// Screen changes are staged in a request register and only committed on a
// frame tick (vblank rising edge) so a frame never mixes two screens.
module game_state_ctl
  import state_pkg::*;
#(
  parameter logic [11:0] START_X0      = START_BTN_X0,
  parameter logic [11:0] START_X1      = START_BTN_X1,
  parameter logic [11:0] START_Y0      = START_BTN_Y0,
  parameter logic [11:0] START_Y1      = START_BTN_Y1,
  parameter logic [11:0] EXIT_X        = LEVEL1_EXIT_X,
  parameter int unsigned FINISH_FRAMES = FINISH_HOLD_FRAMES
) (
  input  logic        clk_40,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic [11:0] xpos_player_ctl1,
  input  logic [11:0] xpos_player_ctl2,
  input  logic [1:0]  button_pressed,
  output g_state      game_state,
  output logic        level_init
);

  localparam logic [7:0] FINISH_LAST = 8'(FINISH_FRAMES - 1);

  logic w_tick;
  logic w_click;

  rise_detect u_vblnk_rise (
    .clk    (clk_40),
    .rst_n  (rst),
    .i_sig  (vblnk),
    .o_rise (w_tick)
  );

  rise_detect u_click_rise (
    .clk    (clk_40),
    .rst_n  (rst),
    .i_sig  (mouse_left),
    .o_rise (w_click)
  );

  g_state     r_state;
  g_state     r_req_state;
  logic       r_req_valid;
  logic [7:0] r_frame_cnt;
  logic       r_level_init;

  g_state     w_state_next;
  g_state     w_req_state_next;
  logic       w_req_valid_next;
  logic [7:0] w_frame_cnt_next;
  logic       w_level_init_next;

  // Click-raised requests may commit on a coincident tick; tick-raised
  // requests always wait for the following tick.
  logic       w_click_req;
  g_state     w_click_state;
  logic       w_tick_req;
  g_state     w_tick_state;
  logic       w_illegal;

  logic w_in_box;
  logic w_win;

  assign w_in_box = in_range(xpos_mouse, START_X0, START_X1) &&
                    in_range(ypos_mouse, START_Y0, START_Y1);
  assign w_win    = (button_pressed == 2'b11) &&
                    (xpos_player_ctl1 >= EXIT_X) &&
                    (xpos_player_ctl2 >= EXIT_X);

  // State, request register, frame counter and level_init pulse.
  always_ff @(posedge clk_40) begin
    if (!rst) begin
      r_state      <= START;
      r_req_state  <= START;
      r_req_valid  <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_level_init <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_req_state  <= w_req_state_next;
      r_req_valid  <= w_req_valid_next;
      r_frame_cnt  <= w_frame_cnt_next;
      r_level_init <= w_level_init_next;
    end
  end

  // Request rules per screen, then frame-boundary commit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_next     = r_state;
    w_req_state_next = r_req_state;
    w_req_valid_next = r_req_valid;
    w_frame_cnt_next = r_frame_cnt;
    w_click_req      = 1'b0;
    w_click_state    = START;
    w_tick_req       = 1'b0;
    w_tick_state     = START;
    w_illegal        = 1'b0;

    case (r_state)
      START: begin
        if (w_click && w_in_box) begin
          w_click_req   = 1'b1;
          w_click_state = LEVEL_1;
        end
      end
      LEVEL_1: begin
        if (w_tick && w_win) begin
          w_tick_req   = 1'b1;
          w_tick_state = FINISH;
        end
      end
      FINISH: begin
        if (w_click) begin
          w_click_req   = 1'b1;
          w_click_state = START;
        end
        if (w_tick && (r_frame_cnt == FINISH_LAST)) begin
          w_tick_req   = 1'b1;
          w_tick_state = START;
        end
        if (w_tick && (r_frame_cnt != 8'hFF)) begin
          w_frame_cnt_next = r_frame_cnt + 8'd1;
        end
      end
      default: begin
        w_illegal        = 1'b1;
        w_state_next     = START;
        w_req_valid_next = 1'b0;
      end
    endcase

    if (!w_illegal) begin
      if (w_tick) begin
        if (r_req_valid) begin
          w_state_next     = r_req_state;
          w_req_valid_next = 1'b0;
        end else if (w_click_req) begin
          w_state_next = w_click_state;
        end else if (w_tick_req) begin
          w_req_valid_next = 1'b1;
          w_req_state_next = w_tick_state;
        end
      end else if (w_click_req && !r_req_valid) begin
        w_req_valid_next = 1'b1;
        w_req_state_next = w_click_state;
      end
    end

    if ((w_state_next == FINISH) && (r_state != FINISH)) begin
      w_frame_cnt_next = 8'd0;
    end

    w_level_init_next = (w_state_next == LEVEL_1) && (r_state != LEVEL_1);
  end

  assign game_state = r_state;
  assign level_init = r_level_init;

endmodule

// File: doc/game_state_ctl.md
# game_state_ctl

Top-level game sequencer that produces the `game_state` consumed by the VGA stage multiplexer (`start_game`). Clocked on the 40 MHz pixel clock. Decides START → LEVEL_1 → FINISH → START from mouse clicks, player positions and plate-button status. Commits every state change only at a frame boundary (vblank rising edge), so a displayed frame never mixes two screens.

## Interface
Parameters:
- `START_X0`, default 350: start-button box, left edge (inclusive).
- `START_X1`, default 450: start-button box, right edge (inclusive).
- `START_Y0`, default 280: start-button box, top edge (inclusive).
- `START_Y1`, default 320: start-button box, bottom edge (inclusive).
- `EXIT_X`, default 740: both players must have xpos ≥ EXIT_X to finish the level.
- `FINISH_FRAMES`, default 180: frames the FINISH screen is held before auto-return (3 s at 60 Hz).

Ports:
- `clk_40`  in  1  pixel clock, 40 MHz.
- `rst`  in  1  reset, synchronous, active-low.
- `vblnk`  in  1  vertical blanking from the timing generator.
- `mouse_left`  in  1  left mouse button level, already in the clk_40 domain.
- `xpos_mouse`, `ypos_mouse`  in  12 each  cursor position.
- `xpos_player_ctl1`, `xpos_player_ctl2`  in  12 each  player x positions.
- `button_pressed`  in  2  plate-button status; bit0 is plate 1, bit1 is plate 2.
- `game_state`  out  g_state  current screen, registered.
- `level_init`  out  1  one-cycle pulse when LEVEL_1 is entered; player controllers reload their start positions on it.

## Operation
- **Frame tick:** `vblnk` is registered into `vblnk_q`. `tick = vblnk & ~vblnk_q`, one cycle per frame.
- **Click:** `mouse_left` is registered into `ml_q`. `click = mouse_left & ~ml_q`.
- **Pending request:** a request register holds a next state plus a valid bit. It is set by the rules below, committed on the next `tick`, then cleared.
  - If a request and a tick occur in the same cycle, the request commits on that tick.
  - Repeated requests before a tick do not stack.
- **START:**
  - A `click` with X0 ≤ xpos_mouse ≤ X1 and Y0 ≤ ypos_mouse ≤ Y1 (all inclusive, unsigned 12-bit compares) requests LEVEL_1.
  - Clicks outside the box are ignored.
- **LEVEL_1:**
  - On each `tick`, if `button_pressed == 2'b11` and both player xpos ≥ EXIT_X, request FINISH. Because the request is raised on a tick, it commits on the following tick.
  - Clicks are ignored in this state.
- **FINISH:**
  - `frame_cnt` is 8-bit, cleared on entry, and increments on each `tick`.
  - When `frame_cnt == FINISH_FRAMES-1` on a tick, or on any `click`, request START.
  - `frame_cnt` saturates and never wraps.
- **Illegal or unencoded `game_state`:** forced to START on the next cycle, with the request register cleared.
- **`level_init`:** asserted for exactly the cycle in which `game_state` first reads LEVEL_1. It is 0 in all other cycles.

## Timing
- **Reset** (rst low at a clk_40 edge) sets:
  - `game_state` = START
  - `level_init` = 0
  - `frame_cnt` = 0
  - request valid = 0
  - `vblnk_q` = 0, `ml_q` = 0
- **Reset mid-operation:** on the first cycle after rst goes high, state is START regardless of what was pending.
- **Latency:**
  - A click at cycle C in the START box, with the next tick at cycle T ≥ C, gives `game_state` = LEVEL_1 at T+1.
  - `level_init` is high at T+1 only.
- **vblnk high at reset release:** if `vblnk` is already high when reset releases, a tick fires immediately, because `vblnk_q` resets to 0. This is accepted behaviour.
- **Click and tick in the same cycle:** the click is evaluated first, and the transition commits on that same tick.
- **LEVEL_1 win latency:** the win condition true at tick k gives FINISH committed at tick k+1, visible one cycle after that tick.
- **FINISH auto-return:** START commits on the tick after `frame_cnt` reaches FINISH_FRAMES-1, i.e. FINISH is shown for FINISH_FRAMES+1 frames.

## Structure
- `g_state` (START, LEVEL_1, FINISH) already lives in `state_pkg`.
- Add to `state_pkg` as defaults for the parameters above:
  - `START_BTN_X0`, `START_BTN_X1`, `START_BTN_Y0`, `START_BTN_Y1`
  - `LEVEL1_EXIT_X`
  - `FINISH_HOLD_FRAMES`
- Sub-module `rise_detect` (one-bit registered edge detector with synchronous active-low reset), instantiated twice: once for `vblnk`, once for `mouse_left`.
- The FSM, request register and `frame_cnt` stay in `game_state_ctl`.

## Test plan
- **Reset mid-LEVEL_1:** drive the design into LEVEL_1, then pulse rst low for 1 cycle → `game_state` = START and `level_init` = 0 on the first cycle after release.
- **Click in box:** click at (400, 300) with vblnk rising 50 cycles later → LEVEL_1 exactly 1 cycle after the tick, and `level_init` high for that cycle only.
- **Click on box edges:** click at (349, 300) → stays START. Click at (450, 320) → LEVEL_1.
- **Win requires both conditions:** in LEVEL_1 with xpos1 = 745, xpos2 = 740 and `button_pressed` = 2'b01 → no change across 5 frames. Set `button_pressed` = 2'b11 → FINISH one tick after the first qualifying tick.
- **FINISH auto-return and early exit:** in FINISH with no clicks → START after 181 frame ticks. A repeat run with a click on frame 10 → START at frame 11's tick.
- **Click and tick together:** click inside the box in the same cycle as the vblnk rise → LEVEL_1 on the next cycle. Hold `mouse_left` high for 3 frames → only one transition and one `level_init` pulse.
